// File: rtl/branch_predictor.sv
// Bimodal branch predictor: 2-bit saturating counters indexed by pc[IDX_W+1:2].
// Optional BP_STATS_EN adds branchCount/mispredCount resolve statistics.
module branch_predictor #(
    parameter int unsigned IDX_W    = 6,
    parameter logic [1:0]  INIT_CNT = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pcF,
    output logic        predTakenF,
    input  logic        resolveE,
    input  logic [31:0] pcE,
    input  logic        takenE,
    input  logic        predTakenE,
    output logic        mispredictE,
    input  logic        enable
`ifdef BP_STATS_EN
    ,
    output logic [31:0] branchCount,
    output logic [31:0] mispredCount
`endif
);

    localparam int unsigned DEPTH = 1 << IDX_W;

    logic [1:0]       cnt_q [DEPTH];
    logic [IDX_W-1:0] idx_f;
    logic [IDX_W-1:0] idx_e;
    logic [1:0]       cur_e;
    logic [1:0]       next_e;
    logic             unused_pc;

    assign idx_f = pcF[IDX_W+1:2];
    assign idx_e = pcE[IDX_W+1:2];
    assign unused_pc = ^{pcF[31:IDX_W+2], pcF[1:0], pcE[31:IDX_W+2], pcE[1:0]};

    // Read path sees the stored value only; an update to the same index shows up next cycle.
    always_comb begin
        predTakenF = enable & cnt_q[idx_f][1];
    end

    always_comb begin
        mispredictE = resolveE & (takenE ^ predTakenE);
    end

    always_comb begin
        cur_e  = cnt_q[idx_e];
        next_e = cur_e;
        if (takenE) begin
            if (cur_e != 2'b11) next_e = cur_e + 2'd1;
        end else begin
            if (cur_e != 2'b00) next_e = cur_e - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= INIT_CNT;
            end
        end else if (resolveE) begin
            cnt_q[idx_e] <= next_e;
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branchCount  <= '0;
            mispredCount <= '0;
        end else begin
            if (resolveE)    branchCount  <= branchCount + 32'd1;
            if (mispredictE) mispredCount <= mispredCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (default IDX_W=6, INIT_CNT=01).
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pcF;
    logic        predTakenF;
    logic        resolveE;
    logic [31:0] pcE;
    logic        takenE;
    logic        predTakenE;
    logic        mispredictE;
    logic        enable;
`ifdef BP_STATS_EN
    logic [31:0] branchCount;
    logic [31:0] mispredCount;
`endif

    int errors = 0;
    int checks = 0;

    branch_predictor #(.IDX_W(6), .INIT_CNT(2'b01)) dut (
        .clk         (clk),
        .rst         (rst),
        .pcF         (pcF),
        .predTakenF  (predTakenF),
        .resolveE    (resolveE),
        .pcE         (pcE),
        .takenE      (takenE),
        .predTakenE  (predTakenE),
        .mispredictE (mispredictE),
        .enable      (enable)
`ifdef BP_STATS_EN
        ,
        .branchCount (branchCount),
        .mispredCount(mispredCount)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then changed away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One resolve pulse across a single rising edge, then resolveE is dropped.
    task automatic resolve(input logic [31:0] pc, input logic tk, input logic pred);
        pcE        = pc;
        takenE     = tk;
        predTakenE = pred;
        resolveE   = 1'b1;
        tick();
        resolveE   = 1'b0;
        #1;
    endtask

    initial begin
        rst        = 1'b0;
        enable     = 1'b1;
        pcF        = '0;
        pcE        = '0;
        resolveE   = 1'b0;
        takenE     = 1'b0;
        predTakenE = 1'b0;

        // Reset sweep across all 64 entries
        for (int i = 0; i < 64; i++) begin
            pcF = i * 4;
            #1;
            check($sformatf("reset_sweep_%0d", i), predTakenF, 1'b0);
        end
        check("reset_mispredict_idle", mispredictE, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;

        // Training ramp at 0x40
        pcE = 32'h40; takenE = 1'b1; predTakenE = 1'b0; resolveE = 1'b1;
        #1;
        check("ramp1_mispredict", mispredictE, 1'b1);
        tick();
        resolveE = 1'b0;
        pcF = 32'h40;
        #1;
        check("ramp1_idle_mispredict", mispredictE, 1'b0);
        check("ramp1_pred", predTakenF, 1'b1);
        predTakenE = 1'b1; resolveE = 1'b1;
        #1;
        check("ramp2_mispredict", mispredictE, 1'b0);
        tick();
        resolve(32'h40, 1'b1, 1'b1);
        check("ramp3_pred", predTakenF, 1'b1);

        // Hysteresis: 11 -> 10 -> 01
        pcE = 32'h40; takenE = 1'b0; predTakenE = 1'b1; resolveE = 1'b1;
        #1;
        check("hyst1_mispredict", mispredictE, 1'b1);
        tick();
        resolveE = 1'b0;
        #1;
        check("hyst1_pred", predTakenF, 1'b1);
        resolve(32'h40, 1'b0, 1'b1);
        check("hyst2_pred", predTakenF, 1'b0);

        // Aliasing 0x140 onto entry 16, with same-cycle read of 0x40
        pcF = 32'h40;
        pcE = 32'h140; takenE = 1'b1; predTakenE = 1'b0; resolveE = 1'b1;
        #1;
        check("alias_old_value", predTakenF, 1'b0);
        tick();
        check("alias_new_value", predTakenF, 1'b1);
        resolveE = 1'b0;
        pcF = 32'h44;
        #1;
        check("alias_neighbour", predTakenF, 1'b0);
        resolve(32'h140, 1'b1, 1'b1);
        pcF = 32'h140;
        #1;
        check("alias_sat_pred", predTakenF, 1'b1);

        // enable = 0 gates prediction while training proceeds (11 -> 10 -> 01)
        pcF = 32'h40;
        enable = 1'b0;
        #1;
        check("disable_pred", predTakenF, 1'b0);
        resolve(32'h40, 1'b0, 1'b0);
        resolve(32'h40, 1'b0, 1'b0);
        enable = 1'b1;
        #1;
        check("disable_trained_pred", predTakenF, 1'b0);

        // Lower saturation at 0x80: 01 -> 00 -> 00 -> 01 -> 10
        resolve(32'h80, 1'b0, 1'b0);
        resolve(32'h80, 1'b0, 1'b0);
        resolve(32'h80, 1'b1, 1'b0);
        pcF = 32'h80;
        #1;
        check("floor_still_nt", predTakenF, 1'b0);
        resolve(32'h80, 1'b1, 1'b0);
        check("floor_recover", predTakenF, 1'b1);

        // Async reset mid-cycle with trained entries; in-flight update dropped
        resolve(32'h40, 1'b1, 1'b0);
        resolve(32'h40, 1'b1, 1'b1);
        pcF = 32'h40;
        #1;
        check("pre_reset_pred", predTakenF, 1'b1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("async_reset_pred", predTakenF, 1'b0);
        pcE = 32'h40; takenE = 1'b1; predTakenE = 1'b0; resolveE = 1'b1;
        #1;
        check("reset_mispredict_comb", mispredictE, 1'b1);
        tick();
        resolveE = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset_discard_update", predTakenF, 1'b0);
        resolve(32'h40, 1'b1, 1'b0);
        check("reset_init_weak_nt", predTakenF, 1'b1);

`ifdef BP_STATS_EN
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("stats_reset_branch", branchCount, 32'd0);
        check("stats_reset_mispred", mispredCount, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            resolve(32'h100 + i * 4, 1'b1, (i < 3) ? 1'b0 : 1'b1);
        end
        tick();
        check("stats_branch", branchCount, 32'd10);
        check("stats_mispred", mispredCount, 32'd3);
        rst = 1'b0;
        #1;
        check("stats_clear_branch", branchCount, 32'd0);
        check("stats_clear_mispred", mispredCount, 32'd0);
        rst = 1'b1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor for the 5-stage RISC-V pipeline.
- Fetch side: looks up a bimodal table of 2-bit saturating counters, indexed by PC, and returns a taken/not-taken prediction.
- Execute side: takes the resolved outcome from the branch controller, trains the table, and flags mispredictions so the hazard unit can flush D/E and redirect fetch.
- Sits between the fetch PC mux and the E-stage branch resolution logic.

Parameters:
- IDX_W, 6, table index width; table depth = 2^IDX_W entries.
- INIT_CNT, 2'b01, counter value loaded into every entry on reset (weakly not-taken).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- pcF  input  32  fetch-stage PC.
- predTakenF  output  1  prediction for the instruction at pcF.
- resolveE  input  1  one-cycle pulse: a conditional branch is resolved in E this cycle.
- pcE  input  32  PC of the resolving branch.
- takenE  input  1  actual outcome (1 = taken), derived from PCSrcE == 2'b01 for branches.
- predTakenE  input  1  prediction carried down the pipeline with the branch.
- mispredictE  output  1  resolveE && (takenE != predTakenE).
- enable  input  1  0 forces predTakenF = 0; training continues.

Behaviour:
- Storage: 2^IDX_W entries × 2 bits. Index = pc[IDX_W+1:2]; pc[1:0] ignored. No tags, so aliasing is permitted.
- Counter encoding:
  - 00 = strong not-taken, 01 = weak not-taken.
  - 10 = weak taken, 11 = strong taken.
  - Prediction = counter[1].
- Reset (rst = 0, asynchronous):
  - every entry = INIT_CNT.
  - predTakenF reflects INIT_CNT[1] (0 by default).
  - mispredictE tracks its inputs (combinational).
- Read path: predTakenF is combinational from pcF and table contents (zero-cycle latency) and is gated by enable.
- Update path:
  - On the rising clk edge with resolveE = 1, entry[idx(pcE)] is updated: +1 if takenE, −1 otherwise, saturating at 11 and 00.
  - No update when resolveE = 0.
- Read/update same index in the same cycle: predTakenF returns the pre-update value. No bypass; the new value is visible the next cycle.
- mispredictE: purely combinational, 0 whenever resolveE = 0.
- JAL/JALR: not predicted by this block. The pipeline holds resolveE low for jumps.
- Stalls: the pipeline must pulse resolveE exactly once per resolved branch. A stalled E stage deasserts resolveE until the branch leaves E.
- Reset mid-operation: asserting rst clears the table immediately regardless of clk. Any in-flight update that cycle is discarded.
- Redirect policy (consumed outside this block):
  - mispredictE with takenE = 1 → PC = branch target.
  - mispredictE with takenE = 0 → PC = pcE + 4.

Optional Feature:
- Macro: BP_STATS_EN.
- Defined:
  - Adds outputs branchCount[31:0] and mispredCount[31:0].
  - branchCount increments on every clk edge with resolveE = 1.
  - mispredCount increments on every clk edge with mispredictE = 1.
  - Both wrap from 0xFFFFFFFF to 0, reset to 0 on rst, and increment in the same cycle as the table update.
- Undefined: the ports and counters do not exist. Table and prediction behaviour are identical.

Test Plan:
- Reset → all lookups predict 0. Sweep pcF over 0x00..0xFC step 4 → predTakenF = 0 for all 64 entries.
- Training ramp, pcE = 0x40, takenE = 1, predTakenE = predicted value:
  - pulse 1 → mispredictE = 1; entry → 10; next cycle pcF = 0x40 gives predTakenF = 1.
  - pulses 2–3 → mispredictE = 0; entry saturates at 11.
- Hysteresis: from 11 at 0x40, one not-taken resolve → entry 10, predTakenF still 1. A second not-taken → 01, predTakenF = 0.
- Aliasing and same-cycle read/write:
  - pcE = 0x140 trains entry 16, which aliases 0x40 (IDX_W = 6).
  - With pcF = 0x40 in the same cycle as the update → old value returned; updated value next cycle.
- Async reset with enable:
  - Drive rst low between clk edges with trained entries → predTakenF = 0 immediately.
  - enable = 0 with entry at 11 → predTakenF = 0, and training still advances the counter.
- With BP_STATS_EN: 10 resolves, 3 mispredicted → branchCount = 10, mispredCount = 3; rst → both 0.
